conv33_stream_ctrl: RTL and testbench

CONV33_STREAM_CTRL -- requirements
Module: conv33_stream_ctrl

---
 rtl/conv33_stream_ctrl.sv | 151 +++++++++++++++
 tb/tb_conv33_stream_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv33_stream_ctrl.sv
// Stream controller for a 3x3 convolution datapath: buffers three image rows,
// then sweeps their columns gap-free into a free-running shift datapath.
module conv33_stream_ctrl #(
  parameter int PIXEL_WIDTH = 8,
  parameter int IMG_W       = 16,
  parameter int IMG_H       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [1:0]             mode_in,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [PIXEL_WIDTH-1:0] s_pixel,
  output logic [PIXEL_WIDTH-1:0] conv_top,
  output logic [PIXEL_WIDTH-1:0] conv_mid,
  output logic [PIXEL_WIDTH-1:0] conv_bot,
  output logic [1:0]             conv_mode,
  input  logic [PIXEL_WIDTH-1:0] conv_pixel,
  output logic                   out_valid,
  output logic [PIXEL_WIDTH-1:0] out_pixel,
  output logic                   out_eol,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);
  localparam int AW = $clog2(IMG_W);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_END  = CW'(IMG_W);
  localparam logic [RW-1:0] ROWS     = RW'(IMG_H);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_SWEEP, S_LOAD, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [1:0]      top_q, top_d;
  logic [1:0]      mode_q, mode_d;

  logic [PIXEL_WIDTH-1:0] line_q [3][IMG_W];

  logic          accept;
  logic          sweep_rd;
  logic [1:0]    wr_slot;
  logic [AW-1:0] col_idx;

  function automatic logic [1:0] slot_inc(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    top_d   = top_q;
    mode_d  = mode_q;
    s_ready = (state_q == S_FILL) || (state_q == S_LOAD);
    accept  = s_valid && s_ready;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FILL;
          mode_d  = mode_in;
          col_d   = '0;
          row_d   = '0;
          top_d   = '0;
        end
      end
      S_FILL: begin
        if (accept) begin
          if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = row_q + RW'(1);
            if (row_q == RW'(2)) state_d = S_SWEEP;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_SWEEP: begin
        // The sweep never waits: the datapath shifts on every clock.
        if (col_q == COL_END) begin
          col_d   = '0;
          state_d = (row_q < ROWS) ? S_LOAD : S_DONE;
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (col_q == LAST_COL) begin
            col_d   = '0;
            row_d   = row_q + RW'(1);
            top_d   = slot_inc(top_q);
            state_d = S_SWEEP;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      top_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      top_q   <= top_d;
      mode_q  <= mode_d;
    end
  end

  // During LOAD the oldest row (the top slot) is the one being replaced.
  assign wr_slot = (state_q == S_FILL) ? row_q[1:0] : top_q;
  assign col_idx = col_q[AW-1:0];

  // NOTE: the line buffer is not reset; every location is written before it is read in a frame.
  always_ff @(posedge clk) begin
    if (accept) line_q[wr_slot][col_idx] <= s_pixel;
  end

  assign sweep_rd  = (state_q == S_SWEEP) && (col_q != COL_END);
  assign conv_top  = sweep_rd ? line_q[top_q][col_idx] : '0;
  assign conv_mid  = sweep_rd ? line_q[slot_inc(top_q)][col_idx] : '0;
  assign conv_bot  = sweep_rd ? line_q[slot_inc(slot_inc(top_q))][col_idx] : '0;
  assign conv_mode = mode_q;

  // The datapath result at sweep cycle k is centred on column k-2.
  assign out_valid = (state_q == S_SWEEP) && (col_q >= CW'(3));
  assign out_eol   = (state_q == S_SWEEP) && (col_q == COL_END);
  assign out_last  = out_eol && (row_q == ROWS);
  assign out_pixel = conv_pixel;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_conv33_stream_ctrl.sv
// Self-checking bench for conv33_stream_ctrl on a 4x4 frame, with a behavioural
// 3x3 datapath model and a scoreboard of expected output pixels.
module tb_conv33_stream_ctrl;

  localparam int PW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode_in = 2'd0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [PW-1:0] s_pixel = '0;
  logic [PW-1:0] conv_top, conv_mid, conv_bot;
  logic [1:0]    conv_mode;
  logic [PW-1:0] conv_pixel;
  logic          out_valid, out_eol, out_last, busy, done;
  logic [PW-1:0] out_pixel;

  conv33_stream_ctrl #(.PIXEL_WIDTH(PW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_in(mode_in),
    .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel),
    .conv_top(conv_top), .conv_mid(conv_mid), .conv_bot(conv_bot),
    .conv_mode(conv_mode), .conv_pixel(conv_pixel),
    .out_valid(out_valid), .out_pixel(out_pixel), .out_eol(out_eol),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural datapath: two column registers plus a registered kernel result.
  typedef struct packed {logic [PW-1:0] t, m, b;} col_t;
  col_t cur, w1 = '0, w2 = '0;
  logic [PW-1:0] res = '0;

  function automatic logic [PW-1:0] kern(input logic [1:0] m, input col_t l, input col_t c, input col_t r);
    int lt = l.t, lm = l.m, lb = l.b, ct = c.t, cm = c.m, cb = c.b, rt = r.t, rm = r.m, rb = r.b;
    int acc;
    case (m)
      2'd0:    acc = cm;
      2'd1:    acc = 5*cm - ct - cb - lm - rm;
      2'd2:    acc = (lt + 2*ct + rt + 2*lm + 4*cm + 2*rm + lb + 2*cb + rb) / 16;
      default: acc = 8*cm - (lt + ct + rt + lm + rm + lb + cb + rb);
    endcase
    if (acc < 0) acc = 0;
    if (acc > 255) acc = 255;
    return PW'(acc);
  endfunction

  assign cur = {conv_top, conv_mid, conv_bot};
  assign conv_pixel = res;

  always @(posedge clk) begin
    res <= kern(conv_mode, w2, w1, cur);
    w1  <= cur;
    w2  <= w1;
  end

  // Scoreboard and output monitor.
  typedef struct packed {logic [PW-1:0] pix; logic eol; logic last;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic prev_last = 1'b0;
  int   frames_done = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_last = 1'b0;
    end else begin
      if (prev_last || done) check("done_pulse", 32'(done), 32'(prev_last));
      if (done) frames_done++;
      if (out_valid) begin
        check("s_ready_in_sweep", 32'(s_ready), 0);
        if (sb.size() == 0) begin
          check("unexpected_out", 32'(sb.size()), 1);
        end else begin
          mon_e = sb.pop_front();
          check("out_pixel", 32'(out_pixel), 32'(mon_e.pix));
          check("out_eol", 32'(out_eol), 32'(mon_e.eol));
          check("out_last", 32'(out_last), 32'(mon_e.last));
        end
      end else begin
        check("flags_without_valid", 32'({out_eol, out_last}), 0);
      end
      prev_last = out_valid && out_last;
    end
  end

  // Column routing checker for ramp frames: sweep s shows rows s, s+1, s+2.
  logic col_chk = 1'b0;
  int   ck_k = 0;
  int   ck_s = 0;

  always @(negedge clk) begin
    if (!rst_n || !busy) begin
      ck_k = 0;
      ck_s = 0;
    end else if (!s_ready && !done) begin
      if (col_chk) begin
        if (ck_k < W) begin
          check("conv_top", 32'(conv_top), 32'(ck_s*W + ck_k));
          check("conv_mid", 32'(conv_mid), 32'((ck_s+1)*W + ck_k));
          check("conv_bot", 32'(conv_bot), 32'((ck_s+2)*W + ck_k));
        end else begin
          check("conv_cols_flush", 32'({conv_top, conv_mid, conv_bot}), 0);
        end
      end
      ck_k++;
      if (ck_k > W) begin
        ck_k = 0;
        ck_s++;
      end
    end
  end

  function automatic logic [PW-1:0] pix_of(input int pat, input int i);
    int r = i / W;
    int c = i % W;
    case (pat)
      0:       return PW'(i);
      1:       return PW'(16);
      2:       return PW'(50);
      default: return ((r + c) % 2 == 1) ? PW'(200) : PW'(10);
    endcase
  endfunction

  task automatic send(input logic [PW-1:0] p);
    int n = 0;
    s_valid = 1'b1;
    s_pixel = p;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_timeout", 32'(n), 0);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic begin_frame(input logic [1:0] m);
    start   = 1'b1;
    mode_in = m;
    @(negedge clk);
    start   = 1'b0;
    mode_in = 2'd3 - m;
  endtask

  typedef struct {
    logic [1:0] mode;
    int pat;
    int gap;
    int poke;
    int e0, e1, e2, e3;
  } vec_t;

  task automatic run_frame(input vec_t v);
    int f0 = frames_done;
    int n  = 0;
    sb.push_back('{pix: PW'(v.e0), eol: 1'b0, last: 1'b0});
    sb.push_back('{pix: PW'(v.e1), eol: 1'b1, last: 1'b0});
    sb.push_back('{pix: PW'(v.e2), eol: 1'b0, last: 1'b0});
    sb.push_back('{pix: PW'(v.e3), eol: 1'b1, last: 1'b1});
    col_chk = (v.pat == 0);
    begin_frame(v.mode);
    for (int i = 0; i < W*H; i++) begin
      if (v.poke != 0 && i == 5) begin
        start   = 1'b1;
        mode_in = 2'd3;
        @(negedge clk);
        start   = 1'b0;
        check("mode_held_on_busy_start", 32'(conv_mode), 32'(v.mode));
      end
      send(pix_of(v.pat, i));
      if (v.gap != 0) @(negedge clk);
    end
    while (frames_done == f0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("frame_done", 32'(frames_done - f0), 1);
    check("sb_drained", 32'(sb.size()), 0);
    check("idle_after_frame", 32'(busy), 0);
    col_chk = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{mode: 2'd0, pat: 0, gap: 0, poke: 0, e0: 5,  e1: 6,   e2: 9,   e3: 10};
    vecs[1] = '{mode: 2'd2, pat: 1, gap: 0, poke: 0, e0: 16, e1: 16,  e2: 16,  e3: 16};
    vecs[2] = '{mode: 2'd3, pat: 2, gap: 0, poke: 0, e0: 0,  e1: 0,   e2: 0,   e3: 0};
    vecs[3] = '{mode: 2'd0, pat: 0, gap: 1, poke: 0, e0: 5,  e1: 6,   e2: 9,   e3: 10};
    vecs[4] = '{mode: 2'd1, pat: 3, gap: 0, poke: 1, e0: 0,  e1: 255, e2: 255, e3: 0};
    vecs[5] = '{mode: 2'd2, pat: 0, gap: 1, poke: 0, e0: 5,  e1: 6,   e2: 9,   e3: 10};

    repeat (3) @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_flags", 32'({out_eol, out_last, busy, done}), 0);
    check("rst_conv_cols", 32'({conv_top, conv_mid, conv_bot}), 0);
    check("rst_conv_mode", 32'(conv_mode), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i]);
      @(negedge clk);
    end

    // Reset during the second sweep discards the frame.
    sb.push_back('{pix: PW'(5), eol: 1'b0, last: 1'b0});
    sb.push_back('{pix: PW'(6), eol: 1'b1, last: 1'b0});
    begin_frame(2'd1);
    for (int i = 0; i < W*H; i++) send(pix_of(0, i));
    check("second_sweep_started", 32'({busy, s_ready}), 32'(2'b10));
    rst_n = 1'b0;
    @(negedge clk);
    check("midframe_rst_out_valid", 32'(out_valid), 0);
    check("midframe_rst_busy", 32'(busy), 0);
    check("midframe_rst_mode", 32'(conv_mode), 0);
    check("midframe_rst_cols", 32'({conv_top, conv_mid, conv_bot}), 0);
    check("midframe_partial_outputs", 32'(sb.size()), 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(vecs[0]);
    @(negedge clk);

    // Start coincident with reset resolves to reset.
    rst_n   = 1'b0;
    start   = 1'b1;
    mode_in = 2'd2;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    check("start_with_rst_busy", 32'(busy), 0);
    check("start_with_rst_mode", 32'(conv_mode), 0);
    @(negedge clk);
    check("start_with_rst_still_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
